cdb_receiver: RTL and testbench

Consumer end of the 3-wide Common Data Bus. Presents `cdb_rdy` to the completion buffer under the all-or-nothing rule, captures every accepted result into a small circular FIFO, and drains stored results in arrival order to a narrower writeback port (ROB completion / register-file write) with a simple valid/ready handshake. It decouples CDB broadcast bandwidth from writeback port count.

---
 rtl/tomasulo_pkg.sv | 15 +
 rtl/cdb_lane_compactor.sv | 34 +++
 rtl/cdb_receiver.sv | 162 ++++++++++++++++
 tb/tb_cdb_receiver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: CDB result payload and receiver sizing defaults.
package tomasulo_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ROB_TAG_W    = 6;
    localparam int unsigned CDB_RX_DEPTH = 8;
    localparam int unsigned WB_PORTS     = 2;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
        logic                 exception;
    } ALU_Result_t;

endpackage

// File: rtl/cdb_lane_compactor.sv
// Packs valid CDB lanes toward lane 0 in ascending lane order, no holes.
module cdb_lane_compactor
    import tomasulo_pkg::*;
#(
    parameter int unsigned LANES = 3
) (
    input  logic [LANES-1:0]              valid,
    input  ALU_Result_t [LANES-1:0]       payload,
    output ALU_Result_t [LANES-1:0]       packed_results,
    output logic [$clog2(LANES+1)-1:0]    count
);

    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [CNT_W-1:0] prefix;

    // Running prefix count gives each valid lane its output slot.
    always_comb begin
        packed_results = '0;
        prefix         = '0;
        for (int i = 0; i < LANES; i++) begin
            if (valid[i]) begin
                for (int k = 0; k < LANES; k++) begin
                    if (prefix == CNT_W'(k)) begin
                        packed_results[k] = payload[i];
                    end
                end
                prefix = prefix + CNT_W'(1);
            end
        end
        count = prefix;
    end

endmodule

// File: rtl/cdb_receiver.sv
// CDB consumer: all-or-nothing accept into a circular FIFO, in-order drain
// to a narrower writeback port. Optional macro CDB_RX_BYPASS_EN adds an
// empty-FIFO combinational bypass from CDB to writeback.
module cdb_receiver
    import tomasulo_pkg::*;
#(
    parameter int unsigned CDB_WIDTH  = 3,
    parameter int unsigned WB_WIDTH   = WB_PORTS,
    parameter int unsigned FIFO_DEPTH = CDB_RX_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  ALU_Result_t [CDB_WIDTH-1:0]       cdb_results,
    input  logic [CDB_WIDTH-1:0]              cdb_valid,
    output logic [CDB_WIDTH-1:0]              cdb_rdy,
    output ALU_Result_t [WB_WIDTH-1:0]        wb_results,
    output logic [WB_WIDTH-1:0]               wb_valid,
    input  logic                              wb_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
    output logic                              rx_empty,
    output logic                              rx_full
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned LCNT_W = $clog2(CDB_WIDTH + 1);

    ALU_Result_t                 buffer [FIFO_DEPTH];
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [CNT_W-1:0]            count;

    ALU_Result_t [WB_WIDTH-1:0]  fifo_results;
    logic [WB_WIDTH-1:0]         fifo_valid;
    logic [SUM_W-1:0]            fifo_avail;
    logic [SUM_W-1:0]            drained;
    logic [SUM_W-1:0]            free_slots;
    logic                        ready;
    logic [CDB_WIDTH-1:0]        accept;
    ALU_Result_t [CDB_WIDTH-1:0] comp;
    logic [LCNT_W-1:0]           acc_cnt;
    logic [SUM_W-1:0]            skip;
    logic [SUM_W-1:0]            wr_cnt;
    ALU_Result_t [CDB_WIDTH-1:0] wr_data;

    // Pointer add modulo FIFO_DEPTH; operands never sum past 2*FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [SUM_W-1:0] base,
                                                  input logic [SUM_W-1:0] offs);
        logic [SUM_W-1:0] sum;
        sum = base + offs;
        if (sum >= SUM_W'(FIFO_DEPTH)) begin
            sum = sum - SUM_W'(FIFO_DEPTH);
        end
        return PTR_W'(sum);
    endfunction

    // Oldest stored entries presented on the writeback lanes.
    always_comb begin
        fifo_valid   = '0;
        fifo_results = '0;
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (SUM_W'(count) > SUM_W'(j)) begin
                fifo_valid[j]   = 1'b1;
                fifo_results[j] = buffer[wrap_add(SUM_W'(head), SUM_W'(j))];
            end
        end
    end

    // Ready from occupancy and same-cycle drain only, never from cdb_valid.
    always_comb begin
        fifo_avail = (SUM_W'(count) > SUM_W'(WB_WIDTH)) ? SUM_W'(WB_WIDTH) : SUM_W'(count);
        drained    = wb_ready ? fifo_avail : '0;
        free_slots = SUM_W'(FIFO_DEPTH) - SUM_W'(count) + drained;
        ready      = rst_n && !flush && (free_slots >= SUM_W'(CDB_WIDTH));
        cdb_rdy    = {CDB_WIDTH{ready}};
        accept     = cdb_valid & cdb_rdy;
    end

    cdb_lane_compactor #(
        .LANES          (CDB_WIDTH)
    ) u_compactor (
        .valid          (accept),
        .payload        (cdb_results),
        .packed_results (comp),
        .count          (acc_cnt)
    );

`ifdef CDB_RX_BYPASS_EN
    // Empty FIFO: forward compacted CDB lanes straight to writeback.
    always_comb begin
        wb_valid   = fifo_valid;
        wb_results = fifo_results;
        skip       = '0;
        if ((count == '0) && !flush) begin
            for (int j = 0; j < WB_WIDTH; j++) begin
                wb_valid[j]   = SUM_W'(acc_cnt) > SUM_W'(j);
                wb_results[j] = wb_valid[j] ? comp[j] : '0;
            end
            if (wb_ready) begin
                skip = (SUM_W'(acc_cnt) > SUM_W'(WB_WIDTH)) ? SUM_W'(WB_WIDTH)
                                                            : SUM_W'(acc_cnt);
            end
        end
    end
`else
    // Writeback driven from stored state only.
    always_comb begin
        wb_valid   = fifo_valid;
        wb_results = fifo_results;
        skip       = '0;
    end
`endif

    // Select the accepted lanes that still need storage, shifted past bypassed ones.
    always_comb begin
        wr_cnt = SUM_W'(acc_cnt) - skip;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            wr_data[k] = '0;
            for (int s = 0; s < CDB_WIDTH; s++) begin
                if (SUM_W'(s) == SUM_W'(k) + skip) begin
                    wr_data[k] = comp[s];
                end
            end
        end
    end

    // Payload storage; never reset, occupancy lives in count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (SUM_W'(k) < wr_cnt) begin
                buffer[wrap_add(SUM_W'(tail), SUM_W'(k))] <= wr_data[k];
            end
        end
    end

    // Pointers and occupancy: dequeue then enqueue, flush clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= wrap_add(SUM_W'(head), drained);
            tail  <= wrap_add(SUM_W'(tail), wr_cnt);
            count <= CNT_W'(SUM_W'(count) - drained + wr_cnt);
        end
    end

    // Status flags.
    always_comb begin
        rx_count = count;
        rx_empty = (count == '0);
        rx_full  = (SUM_W'(count) == SUM_W'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_cdb_receiver.sv
// Bench for cdb_receiver: directed table, reset/bypass sequences and random
// traffic checked against a queue model. Honours CDB_RX_BYPASS_EN.
module tb_cdb_receiver;
    import tomasulo_pkg::*;

    localparam int unsigned CW = 3;
    localparam int unsigned WW = WB_PORTS;
    localparam int unsigned D  = CDB_RX_DEPTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    ALU_Result_t [CW-1:0]   cdb_results = '0;
    logic [CW-1:0]          cdb_valid = '0;
    logic [CW-1:0]          cdb_rdy;
    ALU_Result_t [WW-1:0]   wb_results;
    logic [WW-1:0]          wb_valid;
    logic                   wb_ready = 1'b0;
    logic [$clog2(D+1)-1:0] rx_count;
    logic                   rx_empty;
    logic                   rx_full;

    cdb_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .cdb_results (cdb_results),
        .cdb_valid   (cdb_valid),
        .cdb_rdy     (cdb_rdy),
        .wb_results  (wb_results),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .rx_count    (rx_count),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int next_tag = 1;

    // Reference model: ordered list of stored results plus the pending update.
    ALU_Result_t q[$];
    ALU_Result_t m_push[$];
    int unsigned m_drain;
    logic        m_flush;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic ALU_Result_t mk(input int t);
        ALU_Result_t r;
        r.rob_tag   = ROB_TAG_W'(t);
        r.value     = (32'(t) * 32'h9E37) ^ 32'h5A5A;
        r.exception = (t % 3 == 0);
        return r;
    endfunction

    task automatic drive(input logic fl, input logic [CW-1:0] v,
                         input int t0, input int t1, input int t2, input logic wr);
        flush          = fl;
        cdb_valid      = v;
        cdb_results[0] = mk(t0);
        cdb_results[1] = mk(t1);
        cdb_results[2] = mk(t2);
        wb_ready       = wr;
    endtask

    // Compute expected outputs from the current inputs and queue, record the update.
    task automatic model_check();
        int unsigned n;
        int unsigned dr;
        logic        rdy;
        ALU_Result_t acc[$];
        logic [WW-1:0] ev;
        ALU_Result_t   er [WW];
        n   = q.size();
        dr  = wb_ready ? ((n < WW) ? n : WW) : 0;
        rdy = !flush && (D - n + dr >= CW);
        for (int i = 0; i < CW; i++) begin
            if (cdb_valid[i] && rdy) acc.push_back(cdb_results[i]);
        end
        ev = '0;
        for (int j = 0; j < WW; j++) begin
            er[j] = '0;
            if (j < n) begin
                ev[j] = 1'b1;
                er[j] = q[j];
            end
        end
        m_push  = acc;
        m_drain = dr;
        m_flush = flush;
`ifdef CDB_RX_BYPASS_EN
        if (n == 0 && !flush) begin
            for (int j = 0; j < WW; j++) begin
                if (j < acc.size()) begin
                    ev[j] = 1'b1;
                    er[j] = acc[j];
                end
            end
            if (wb_ready) begin
                for (int j = 0; j < WW; j++) begin
                    if (m_push.size() > 0 && j < acc.size()) void'(m_push.pop_front());
                end
            end
        end
`endif
        chk("cdb_rdy", 128'(cdb_rdy), 128'({CW{rdy}}));
        chk("wb_valid", 128'(wb_valid), 128'(ev));
        for (int j = 0; j < WW; j++) begin
            if (ev[j] || ev == '0) chk($sformatf("wb_results[%0d]", j), 128'(wb_results[j]), 128'(er[j]));
        end
        chk("rx_count", 128'(rx_count), 128'(n));
        chk("rx_empty", 128'(rx_empty), 128'(n == 0));
        chk("rx_full", 128'(rx_full), 128'(n == D));
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        if (m_flush) begin
            q.delete();
        end else begin
            repeat (m_drain) void'(q.pop_front());
            foreach (m_push[i]) q.push_back(m_push[i]);
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic fl, input logic [CW-1:0] v, input logic wr);
        drive(fl, v, next_tag, next_tag + 1, next_tag + 2, wr);
        next_tag += 3;
        #1;
        model_check();
        finish_cycle();
    endtask

    typedef struct {
        logic          fl;
        logic [CW-1:0] v;
        int            t0, t1, t2;
        logic          wr;
        logic [WW-1:0] e_wbv;
        int            e_t0, e_t1;
        logic [CW-1:0] e_rdy;
        int            e_cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 3'b101, 1, 0, 3,    1'b1, 2'b00, 0, 0,  3'b111, 0};
        tbl[1]  = '{1'b0, 3'b111, 4, 5, 6,    1'b1, 2'b11, 1, 3,  3'b111, 2};
        tbl[2]  = '{1'b0, 3'b000, 0, 0, 0,    1'b1, 2'b11, 4, 5,  3'b111, 3};
        tbl[3]  = '{1'b0, 3'b000, 0, 0, 0,    1'b1, 2'b01, 6, 0,  3'b111, 1};
        tbl[4]  = '{1'b0, 3'b000, 0, 0, 0,    1'b0, 2'b00, 0, 0,  3'b111, 0};
        tbl[5]  = '{1'b0, 3'b111, 7, 8, 9,    1'b0, 2'b00, 0, 0,  3'b111, 0};
        tbl[6]  = '{1'b0, 3'b111, 10, 11, 12, 1'b0, 2'b11, 7, 8,  3'b111, 3};
        tbl[7]  = '{1'b0, 3'b111, 13, 14, 15, 1'b0, 2'b11, 7, 8,  3'b000, 6};
        tbl[8]  = '{1'b0, 3'b111, 13, 14, 15, 1'b1, 2'b11, 7, 8,  3'b111, 6};
        tbl[9]  = '{1'b0, 3'b000, 0, 0, 0,    1'b0, 2'b11, 9, 10, 3'b000, 7};
        tbl[10] = '{1'b1, 3'b111, 16, 17, 18, 1'b1, 2'b11, 9, 10, 3'b000, 7};
        tbl[11] = '{1'b0, 3'b000, 0, 0, 0,    1'b1, 2'b00, 0, 0,  3'b111, 0};

        // Reset state.
        #1;
        chk("reset cdb_rdy", 128'(cdb_rdy), 128'(0));
        chk("reset wb_valid", 128'(wb_valid), 128'(0));
        chk("reset wb_results", 128'(wb_results), 128'(0));
        chk("reset rx_empty", 128'(rx_empty), 128'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset cdb_rdy", 128'(cdb_rdy), 128'(3'b111));

`ifndef CDB_RX_BYPASS_EN
        // Directed table: gaps ordering, back-pressure, flush.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fl, tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].wr);
            #1;
            chk($sformatf("tbl%0d cdb_rdy", i), 128'(cdb_rdy), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d wb_valid", i), 128'(wb_valid), 128'(tbl[i].e_wbv));
            chk($sformatf("tbl%0d rx_count", i), 128'(rx_count), 128'(tbl[i].e_cnt));
            if (tbl[i].e_wbv[0]) chk($sformatf("tbl%0d tag0", i), 128'(wb_results[0].rob_tag), 128'(ROB_TAG_W'(tbl[i].e_t0)));
            if (tbl[i].e_wbv[1]) chk($sformatf("tbl%0d tag1", i), 128'(wb_results[1].rob_tag), 128'(ROB_TAG_W'(tbl[i].e_t1)));
            model_check();
            finish_cycle();
        end
`endif

        // Reset mid-operation with 5 stored entries.
        cycle(1'b0, 3'b111, 1'b0);
        cycle(1'b0, 3'b011, 1'b0);
        drive(1'b0, 3'b111, 50, 51, 52, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst cdb_rdy", 128'(cdb_rdy), 128'(0));
        chk("midrst wb_valid", 128'(wb_valid), 128'(0));
        chk("midrst wb_results", 128'(wb_results), 128'(0));
        chk("midrst rx_count", 128'(rx_count), 128'(0));
        chk("midrst rx_empty", 128'(rx_empty), 128'(1));
        chk("midrst rx_full", 128'(rx_full), 128'(0));
        q.delete();
        @(negedge clk);
        drive(1'b0, 3'b000, 0, 0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release cdb_rdy", 128'(cdb_rdy), 128'(3'b111));
        @(negedge clk);

`ifdef CDB_RX_BYPASS_EN
        // Bypass: empty FIFO forwards X,Y same cycle, Z stored for one cycle.
        drive(1'b0, 3'b111, 40, 41, 42, 1'b1);
        #1;
        chk("byp wb_valid", 128'(wb_valid), 128'(2'b11));
        chk("byp tag0", 128'(wb_results[0].rob_tag), 128'(ROB_TAG_W'(40)));
        chk("byp tag1", 128'(wb_results[1].rob_tag), 128'(ROB_TAG_W'(41)));
        model_check();
        finish_cycle();
        drive(1'b0, 3'b000, 0, 0, 0, 1'b1);
        #1;
        chk("byp2 wb_valid", 128'(wb_valid), 128'(2'b01));
        chk("byp2 tag0", 128'(wb_results[0].rob_tag), 128'(ROB_TAG_W'(42)));
        chk("byp2 rx_count", 128'(rx_count), 128'(1));
        model_check();
        finish_cycle();
`endif

        // Wrap-around: 20 cycles of 3-wide input with toggling wb_ready.
        for (int i = 0; i < 20; i++) cycle(1'b0, 3'b111, (i % 2 == 0));
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b000, 1'b1);
        chk("wrap drained", 128'(rx_empty), 128'(1));

        // Flush with 4 stored while CDB is valid.
        cycle(1'b0, 3'b111, 1'b0);
        cycle(1'b0, 3'b001, 1'b0);
        cycle(1'b1, 3'b111, 1'b1);
        chk("flush rx_empty", 128'(rx_empty), 128'(1));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(31) == 0), CW'($urandom), ($urandom_range(3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
